// File: rtl/pair_serializer.sv
// Two-entry complex-pair buffer that emits each pair as two consecutive registered samples.
// Optional sticky overflow flag: define PAIR_SERIALIZER_OVF_FLAG_EN.
module pair_serializer #(
  parameter int bit_width = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [bit_width-1:0] Re_i1,
  input  logic signed [bit_width-1:0] Im_i1,
  input  logic signed [bit_width-1:0] Re_i2,
  input  logic signed [bit_width-1:0] Im_i2,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [bit_width-1:0] Re_o,
  output logic signed [bit_width-1:0] Im_o,
  output logic                        out_valid,
  output logic                        out_first,
  output logic                        ovf_err
);

  localparam int fifo_depth = 2;

  typedef struct packed {
    logic [bit_width-1:0] re1;
    logic [bit_width-1:0] im1;
    logic [bit_width-1:0] re2;
    logic [bit_width-1:0] im2;
  } pair_t;

  typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

  state_t               state_q, state_d;
  pair_t                mem_q [fifo_depth];
  pair_t                mem_d [fifo_depth];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [bit_width-1:0] re_q, re_d;
  logic [bit_width-1:0] im_q, im_d;
  logic                 valid_q, valid_d;
  logic                 first_q, first_d;
  logic                 push, pop;
  pair_t                head;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ready = ~rst & (count_q < 2'd2);
    push     = in_valid & in_ready;
    pop      = 1'b0;
    head     = mem_q[rd_ptr_q];
    state_d  = state_q;
    re_d     = re_q;
    im_d     = im_q;
    valid_d  = valid_q;
    first_d  = first_q;
    mem_d    = mem_q;

    unique case (state_q)
      SEND1: begin
        state_d = SEND2;
        re_d    = head.re2;
        im_d    = head.im2;
        valid_d = 1'b1;
        first_d = 1'b0;
        pop     = 1'b1;
      end
      default: begin
        // IDLE and SEND2 share the "start next pair if one is buffered" rule.
        if (count_q != 2'd0) begin
          state_d = SEND1;
          re_d    = head.re1;
          im_d    = head.im1;
          valid_d = 1'b1;
          first_d = 1'b1;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase

    if (push) mem_d[wr_ptr_q] = '{re1: Re_i1, im1: Im_i1, re2: Re_i2, im2: Im_i2};

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the pair storage has no reset; occupancy and pointers decide what
  // is valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      re_q     <= '0;
      im_q     <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      re_q     <= re_d;
      im_q     <= im_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
    end
  end

`ifdef PAIR_SERIALIZER_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

  assign Re_o      = re_q;
  assign Im_o      = im_q;
  assign out_valid = valid_q;
  assign out_first = first_q;

endmodule

// File: tb/tb_pair_serializer.sv
// Self-checking bench for pair_serializer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_pair_serializer;

`ifdef PAIR_SERIALIZER_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] re1, im1, re2, im2;
  } pair_t;

  logic        clk, rst, in_valid, in_ready, out_valid, out_first, ovf_err;
  logic [15:0] re_i1, im_i1, re_i2, im_i2, re_o, im_o;

  pair_serializer #(.bit_width(16)) dut (
    .clk(clk), .rst(rst),
    .Re_i1(re_i1), .Im_i1(im_i1), .Re_i2(re_i2), .Im_i2(im_i2),
    .in_valid(in_valid), .in_ready(in_ready),
    .Re_o(re_o), .Im_o(im_o),
    .out_valid(out_valid), .out_first(out_first), .ovf_err(ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered pairs in a queue, plus which sample of the head
  // pair is currently on the output (0 none, 1 first, 2 second).
  pair_t       mq[$];
  int          shown = 0;
  logic [15:0] m_re = '0, m_im = '0;
  bit          m_valid = 0, m_first = 0, m_ovf = 0;
  int          run = 0, best_run = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input pair_t p);
    bit ready;
    rst = r; in_valid = v;
    re_i1 = p.re1; im_i1 = p.im1; re_i2 = p.re2; im_i2 = p.im2;
    if (r) begin
      mq.delete();
      shown = 0; m_re = '0; m_im = '0; m_valid = 0; m_first = 0; m_ovf = 0;
    end else begin
      ready = (mq.size() < 2);
      if (v && !ready && OVF_EN) m_ovf = 1;
      if (shown == 1) begin
        m_re = mq[0].re2; m_im = mq[0].im2; m_valid = 1; m_first = 0;
        void'(mq.pop_front());
        shown = 2;
      end else if (mq.size() > 0) begin
        m_re = mq[0].re1; m_im = mq[0].im1; m_valid = 1; m_first = 1;
        shown = 1;
      end else begin
        m_valid = 0; shown = 0;
      end
      if (v && ready) mq.push_back(p);
    end
    @(posedge clk);
    #1;
    check("out_valid", 16'(out_valid), 16'(m_valid));
    check("out_first", 16'(out_first), 16'(m_first));
    check("re_o", re_o, m_re);
    check("im_o", im_o, m_im);
    check("in_ready", 16'(in_ready), 16'(!r && mq.size() < 2));
    check("ovf_err", 16'(ovf_err), 16'(m_ovf));
    run = out_valid ? run + 1 : 0;
    if (run > best_run) best_run = run;
  endtask

  function automatic pair_t mk(input int a, input int b, input int c, input int d);
    pair_t p;
    p.re1 = 16'(a); p.im1 = 16'(b); p.re2 = 16'(c); p.im2 = 16'(d);
    return p;
  endfunction

  function automatic pair_t rnd();
    return mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endfunction

  initial begin
    pair_t z;
    z = mk(0, 0, 0, 0);
    rst = 1; in_valid = 0; re_i1 = '0; im_i1 = '0; re_i2 = '0; im_i2 = '0;

    // Reset state, in_ready held low while reset is asserted.
    cycle(1, 0, z);
    cycle(1, 1, mk(9, 9, 9, 9));
    cycle(0, 0, z);

    // Single pair into an idle block.
    cycle(0, 1, mk(1, 2, 3, 4));
    cycle(0, 0, z);
    check("single_s1_re", re_o, 16'd1);
    check("single_s1_im", im_o, 16'd2);
    check("single_s1_first", 16'(out_first), 16'd1);
    cycle(0, 0, z);
    check("single_s2_re", re_o, 16'd3);
    check("single_s2_im", im_o, 16'd4);
    check("single_s2_first", 16'(out_first), 16'd0);
    cycle(0, 0, z);
    check("single_done_valid", 16'(out_valid), 16'd0);
    check("single_hold_re", re_o, 16'd3);

    // One pair every two cycles sustains an unbroken output stream.
    run = 0; best_run = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, mk(4*i + 10, 4*i + 11, 4*i + 12, 4*i + 13));
      cycle(0, 0, z);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, z);
    check("stream_run_len", 16'(best_run), 16'd16);

    // Burst into a full buffer: third pair is dropped.
    cycle(0, 1, mk(100, 101, 102, 103));
    cycle(0, 1, mk(200, 201, 202, 203));
    check("burst_full_ready", 16'(in_ready), 16'd0);
    cycle(0, 1, mk(300, 301, 302, 303));
    check("burst_ovf", 16'(ovf_err), 16'(OVF_EN));
    for (int i = 0; i < 6; i++) cycle(0, 0, z);
    cycle(1, 0, z);
    cycle(0, 0, z);

    // Signed extremes pass bit-exact.
    cycle(0, 1, mk(-32768, 32767, 32767, -32768));
    cycle(0, 0, z);
    check("ext_s1_re", re_o, 16'h8000);
    check("ext_s1_im", im_o, 16'h7fff);
    cycle(0, 0, z);
    check("ext_s2_re", re_o, 16'h7fff);
    check("ext_s2_im", im_o, 16'h8000);
    cycle(0, 0, z);

    // Reset during SEND1 with one pair buffered discards everything.
    cycle(0, 1, mk(51, 52, 53, 54));
    cycle(0, 1, mk(61, 62, 63, 64));
    check("pre_rst_first", 16'(out_first), 16'd1);
    cycle(1, 0, z);
    check("rst_mid_valid", 16'(out_valid), 16'd0);
    check("rst_mid_re", re_o, 16'd0);
    cycle(0, 0, z);
    check("rst_rel_ready", 16'(in_ready), 16'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, z);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), rnd());
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
